// File: rtl/udp_screamer_if.sv
// UDP TX header bus and 8-bit AXIS payload bus used by udp_screamer.
// Header fields are qualified by hdr_valid; payload by tvalid.
interface udp_tx_hdr_if;
    logic        hdr_valid;
    logic        hdr_ready;
    logic [5:0]  ip_dscp;
    logic [1:0]  ip_ecn;
    logic [7:0]  ip_ttl;
    logic [31:0] ip_source_ip;
    logic [31:0] ip_dest_ip;
    logic [15:0] udp_source_port;
    logic [15:0] udp_dest_port;
    logic [15:0] udp_length;
    logic [15:0] udp_checksum;

    modport source (
        output hdr_valid, ip_dscp, ip_ecn, ip_ttl,
        output ip_source_ip, ip_dest_ip,
        output udp_source_port, udp_dest_port,
        output udp_length, udp_checksum,
        input  hdr_ready
    );

    modport sink (
        input  hdr_valid, ip_dscp, ip_ecn, ip_ttl,
        input  ip_source_ip, ip_dest_ip,
        input  udp_source_port, udp_dest_port,
        input  udp_length, udp_checksum,
        output hdr_ready
    );
endinterface

interface axis_if;
    logic       tvalid;
    logic       tready;
    logic [7:0] tdata;
    logic       tlast;
    logic       tuser;

    modport master (
        output tvalid, tdata, tlast, tuser,
        input  tready
    );

    modport slave (
        input  tvalid, tdata, tlast, tuser,
        output tready
    );
endinterface

// File: rtl/udp_screamer.sv
// udp_screamer: periodic fixed-length UDP datagram generator.
// Define UDP_SCREAMER_SEQ_EN to put a 32-bit sequence number in bytes 0..3.
module udp_screamer #(
    parameter logic [15:0] SRC_PORT    = 16'd1234,
    parameter logic [15:0] DEST_PORT   = 16'd1234,
    parameter int          PAYLOAD_LEN = 64,
    parameter int          INTERVAL    = 125000,
    parameter logic [7:0]  TTL         = 8'd64
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         enable,
    input  logic [31:0]  local_ip,
    input  logic [31:0]  dest_ip,
    udp_tx_hdr_if.source udp_tx_header_if,
    axis_if.master       udp_tx_payload_if,
    output logic [31:0]  packets_sent,
    output logic         busy
);

`ifdef UDP_SCREAMER_SEQ_EN
    localparam int MIN_LEN = 4;
`else
    localparam int MIN_LEN = 1;
`endif

    if (PAYLOAD_LEN < MIN_LEN || PAYLOAD_LEN > 1472) begin : g_bad_len
        $error("udp_screamer: PAYLOAD_LEN out of range");
    end

    localparam int CW = (INTERVAL > 1) ? $clog2(INTERVAL) : 1;
    localparam logic [CW-1:0] WAIT_LAST = CW'((INTERVAL > 0) ? INTERVAL - 1 : 0);
    localparam logic [10:0] LAST_IDX = 11'(PAYLOAD_LEN - 1);
    localparam logic [15:0] UDP_LEN = 16'(PAYLOAD_LEN + 8);

    typedef enum logic [1:0] {
        IDLE,
        HEADER,
        PAYLOAD,
        WAIT
    } state_t;

    state_t state;
    state_t state_nxt;

    logic [10:0]   idx;
    logic [CW-1:0] wcnt;
    logic [7:0]    tdata;
    logic          hdr_fire;
    logic          beat;
    logic          last_fire;
    logic          wait_done;
    logic          launch;

    logic [31:0] src_ip;
    logic [31:0] dst_ip;
    logic [7:0]  ttl;
    logic [15:0] sport;
    logic [15:0] dport;
    logic [15:0] ulen;

    assign hdr_fire  = udp_tx_header_if.hdr_valid && udp_tx_header_if.hdr_ready;
    assign beat      = udp_tx_payload_if.tvalid && udp_tx_payload_if.tready;
    assign last_fire = beat && udp_tx_payload_if.tlast;
    assign wait_done = (wcnt == WAIT_LAST);
    // Every entry into HEADER, including PAYLOAD->HEADER when INTERVAL is 0.
    assign launch    = (state != HEADER) && (state_nxt == HEADER);

    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: begin
                if (enable) state_nxt = HEADER;
            end
            HEADER: begin
                if (hdr_fire) state_nxt = PAYLOAD;
            end
            PAYLOAD: begin
                if (last_fire) begin
                    if (INTERVAL != 0) state_nxt = WAIT;
                    else if (enable)   state_nxt = HEADER;
                    else               state_nxt = IDLE;
                end
            end
            WAIT: begin
                if (!enable)        state_nxt = IDLE;
                else if (wait_done) state_nxt = HEADER;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            idx          <= '0;
            wcnt         <= '0;
            packets_sent <= '0;
        end else begin
            if (last_fire) begin
                idx <= '0;
            end else if (beat) begin
                idx <= idx + 11'd1;
            end
            // Counter only runs while WAIT persists; any exit clears it.
            if (state == WAIT && state_nxt == WAIT) begin
                wcnt <= wcnt + CW'(1);
            end else begin
                wcnt <= '0;
            end
            if (last_fire) begin
                packets_sent <= packets_sent + 32'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            src_ip <= '0;
            dst_ip <= '0;
            ttl    <= '0;
            sport  <= '0;
            dport  <= '0;
            ulen   <= '0;
        end else if (launch) begin
            src_ip <= local_ip;
            dst_ip <= dest_ip;
            ttl    <= TTL;
            sport  <= SRC_PORT;
            dport  <= DEST_PORT;
            ulen   <= UDP_LEN;
        end
    end

`ifdef UDP_SCREAMER_SEQ_EN
    logic [31:0] seq;

    // On a back-to-back launch packets_sent is incrementing on the same edge.
    always_ff @(posedge clk) begin
        if (!reset) begin
            seq <= '0;
        end else if (launch) begin
            seq <= last_fire ? packets_sent + 32'd1 : packets_sent;
        end
    end

    always_comb begin
        tdata = idx[7:0];
        if (idx[10:2] == 9'd0) begin
            unique case (idx[1:0])
                2'd0:    tdata = seq[31:24];
                2'd1:    tdata = seq[23:16];
                2'd2:    tdata = seq[15:8];
                default: tdata = seq[7:0];
            endcase
        end
    end
`else
    assign tdata = idx[7:0];
`endif

    assign udp_tx_header_if.hdr_valid       = (state == HEADER);
    assign udp_tx_header_if.ip_dscp         = 6'd0;
    assign udp_tx_header_if.ip_ecn          = 2'd0;
    assign udp_tx_header_if.ip_ttl          = ttl;
    assign udp_tx_header_if.ip_source_ip    = src_ip;
    assign udp_tx_header_if.ip_dest_ip      = dst_ip;
    assign udp_tx_header_if.udp_source_port = sport;
    assign udp_tx_header_if.udp_dest_port   = dport;
    assign udp_tx_header_if.udp_length      = ulen;
    assign udp_tx_header_if.udp_checksum    = 16'd0;

    assign udp_tx_payload_if.tvalid = (state == PAYLOAD);
    assign udp_tx_payload_if.tdata  = tdata;
    assign udp_tx_payload_if.tlast  = (state == PAYLOAD) && (idx == LAST_IDX);
    assign udp_tx_payload_if.tuser  = 1'b0;

    assign busy = (state == HEADER) || (state == PAYLOAD);

endmodule
